// File: rtl/gin_multicast.sv
// gin_multicast: tagged multicast network front end.
// A small FIFO buffers {row_tag, col_tag, value} entries; the head entry is
// matched against scan-loaded per-row and per-PE IDs and is delivered to all
// of its targets in one all-or-nothing cycle. Heads with no target are dropped.

// Per-PE tag match: a tag of all ones is a wildcard for that dimension.
module gin_multicast_pe_match #(
    parameter int ROW_LEN = 4,
    parameter int ID_LEN  = 5
) (
    input  logic [ROW_LEN-1:0] row_tag,
    input  logic [ROW_LEN-1:0] row_id,
    input  logic [ID_LEN-1:0]  col_tag,
    input  logic [ID_LEN-1:0]  col_id,
    output logic               hit
);
    assign hit = ((row_tag == row_id) | (&row_tag)) &
                 ((col_tag == col_id) | (&col_tag));
endmodule

module gin_multicast #(
    parameter int ROWS       = 12,
    parameter int COLS       = 14,
    parameter int ROW_LEN    = 4,
    parameter int ID_LEN     = 5,
    parameter int VALUE_LEN  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_row,
    input  logic [ROW_LEN-1:0]     row_scan_in,
    output logic [ROW_LEN-1:0]     row_scan_out,
    input  logic                   set_id,
    input  logic [ID_LEN-1:0]      id_scan_in,
    output logic [ID_LEN-1:0]      id_scan_out,
    input  logic                   enable,
    output logic                   ready,
    input  logic [ROW_LEN-1:0]     row_tag,
    input  logic [ID_LEN-1:0]      col_tag,
    input  logic [VALUE_LEN-1:0]   value,
    input  logic [ROWS*COLS-1:0]   pe_ready,
    output logic [ROWS*COLS-1:0]   pe_valid,
    output logic [VALUE_LEN-1:0]   pe_value,
    output logic [15:0]            drop_count,
    output logic                   busy
);
    localparam int NPE = ROWS * COLS;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [ROW_LEN-1:0]   row_tag;
        logic [ID_LEN-1:0]    col_tag;
        logic [VALUE_LEN-1:0] value;
    } entry_t;

    logic [ROWS-1:0][ROW_LEN-1:0] row_id;
    logic [NPE-1:0][ID_LEN-1:0]   col_id;

    entry_t        fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    entry_t        head;
    logic          head_vld, scan, push, pop, dispatch, drop;
    logic          any_tgt, all_rdy;
    logic [NPE-1:0] tgt;

    assign scan     = set_row | set_id;
    assign head     = fifo_q[rd_ptr];
    assign head_vld = (count != '0);

    // ready is gated by the reset pin so it is low while reset is held
    assign ready = rst & (count != FULL) & ~scan;
    assign push  = enable & ready;

    // One match instance per PE
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            gin_multicast_pe_match #(.ROW_LEN(ROW_LEN), .ID_LEN(ID_LEN)) u_match (
                .row_tag (head.row_tag),
                .row_id  (row_id[r]),
                .col_tag (head.col_tag),
                .col_id  (col_id[r*COLS+c]),
                .hit     (tgt[r*COLS+c])
            );
        end
    end

    assign any_tgt  = |tgt;
    assign all_rdy  = &(~tgt | pe_ready);
    // Scan mode freezes the FIFO: nothing is delivered or dropped
    assign dispatch = head_vld & ~scan & any_tgt & all_rdy;
    assign drop     = head_vld & ~scan & ~any_tgt;
    assign pop      = dispatch | drop;

    assign pe_valid     = dispatch ? tgt : '0;
    assign pe_value     = head_vld ? head.value : '0;
    assign busy         = head_vld;
    assign row_scan_out = row_id[ROWS-1];
    assign id_scan_out  = col_id[NPE-1];

    // Row-ID scan chain, index 0 receives the scan input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_id <= '0;
        end else if (set_row) begin
            row_id[0] <= row_scan_in;
            for (int r = 1; r < ROWS; r++) row_id[r] <= row_id[r-1];
        end
    end

    // Column-ID scan chain across all PEs, index 0 receives the scan input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_id <= '0;
        end else if (set_id) begin
            col_id[0] <= id_scan_in;
            for (int k = 1; k < NPE; k++) col_id[k] <= col_id[k-1];
        end
    end

    // FIFO storage; validity is tracked by count, so no reset is needed here
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= '{row_tag: row_tag, col_tag: col_tag, value: value};
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of heads discarded for lack of any target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_gin_multicast.sv
// Bench for gin_multicast (ROWS=2, COLS=3, FIFO_DEPTH=4): queue-based model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_gin_multicast;
    localparam int ROWS = 2, COLS = 3, NPE = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_row, set_id, enable;
    logic [3:0]  row_scan_in, row_scan_out, row_tag;
    logic [4:0]  id_scan_in, id_scan_out, col_tag;
    logic [31:0] value, pe_value;
    logic [5:0]  pe_ready, pe_valid;
    logic [15:0] drop_count;
    logic        ready, busy;

    int n_pass = 0;
    int n_total = 0;

    gin_multicast #(.ROWS(2), .COLS(3), .ROW_LEN(4), .ID_LEN(5),
                    .VALUE_LEN(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .set_row(set_row), .row_scan_in(row_scan_in), .row_scan_out(row_scan_out),
        .set_id(set_id), .id_scan_in(id_scan_in), .id_scan_out(id_scan_out),
        .enable(enable), .ready(ready), .row_tag(row_tag), .col_tag(col_tag),
        .value(value), .pe_ready(pe_ready), .pe_valid(pe_valid),
        .pe_value(pe_value), .drop_count(drop_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [3:0] r; logic [4:0] c; logic [31:0] v; } ent_t;
    ent_t       mq[$];
    logic [3:0] m_row[ROWS] = '{default: '0};
    logic [4:0] m_col[NPE]  = '{default: '0};
    int         m_drop = 0;

    function automatic logic [5:0] m_mask();
        logic [5:0] m = '0;
        if (mq.size() == 0) return '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if ((mq[0].r == m_row[r] || mq[0].r == 4'hF) &&
                    (mq[0].c == m_col[r*COLS+c] || mq[0].c == 5'h1F))
                    m[r*COLS+c] = 1'b1;
        return m;
    endfunction

    function automatic logic m_deliver();
        logic [5:0] m = m_mask();
        return mq.size() != 0 && !(set_row || set_id) && m != 0 && (m & ~pe_ready) == 0;
    endfunction

    // Model state advance at each rising edge
    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_row = '{default: '0};
            m_col = '{default: '0};
            m_drop = 0;
        end else begin
            logic scan, do_pop, do_drop, do_push;
            ent_t e;
            scan    = set_row || set_id;
            do_pop  = m_deliver();
            do_drop = mq.size() != 0 && !scan && m_mask() == 0;
            do_push = enable && mq.size() != 4 && !scan;
            if (do_drop && m_drop < 65535) m_drop++;
            if (do_pop || do_drop) void'(mq.pop_front());
            if (do_push) begin
                e.r = row_tag; e.c = col_tag; e.v = value;
                mq.push_back(e);
            end
            if (set_row) begin
                for (int r = ROWS-1; r > 0; r--) m_row[r] = m_row[r-1];
                m_row[0] = row_scan_in;
            end
            if (set_id) begin
                for (int k = NPE-1; k > 0; k--) m_col[k] = m_col[k-1];
                m_col[0] = id_scan_in;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_ready", ready, 0);
            chk("rst_pe_valid", pe_valid, 0);
            chk("rst_pe_value", pe_value, 0);
            chk("rst_busy", busy, 0);
            chk("rst_scan_out", {row_scan_out, id_scan_out}, 0);
            chk("rst_drop", drop_count, 0);
        end else begin
            chk("m_ready", ready, mq.size() != 4 && !(set_row || set_id));
            chk("m_pe_valid", pe_valid, m_deliver() ? m_mask() : 6'd0);
            chk("m_pe_value", pe_value, mq.size() != 0 ? mq[0].v : 32'd0);
            chk("m_busy", busy, mq.size() != 0);
            chk("m_row_scan_out", row_scan_out, m_row[ROWS-1]);
            chk("m_id_scan_out", id_scan_out, m_col[NPE-1]);
            chk("m_drop_count", drop_count, m_drop);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [4:0] c, input logic [31:0] v);
        chk("push_ready", ready, 1);
        enable = 1; row_tag = r; col_tag = c; value = v;
        tick();
        enable = 0;
    endtask

    initial begin
        logic [4:0] ids_a[6];
        logic [4:0] ids_b[6];
        ids_a = '{5'd2, 5'd1, 5'd0, 5'd2, 5'd1, 5'd0};
        ids_b = '{5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd2};
        rst = 0; set_row = 0; set_id = 0; enable = 0;
        row_scan_in = 0; id_scan_in = 0; row_tag = 0; col_tag = 0; value = 0;
        pe_ready = '1;
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_busy", busy, 0);
        tick(); tick();
        rst = 1;
        @(negedge clk);
        chk("ready_after_release", ready, 1);
        tick();

        // rows {0,1}, cols {0,1,2} per row
        set_row = 1; row_scan_in = 4'd1; tick();
        row_scan_in = 4'd0; tick();
        set_row = 0;
        set_id = 1;
        for (int i = 0; i < 6; i++) begin id_scan_in = ids_a[i]; tick(); end
        set_id = 0;
        @(negedge clk);
        chk("row_scan_out", row_scan_out, 4'd1);
        chk("id_scan_out", id_scan_out, 5'd2);
        tick();

        // unicast
        push(4'd1, 5'd2, 32'hA5);
        @(negedge clk);
        chk("uni_valid", pe_valid, 6'b100000);
        chk("uni_value", pe_value, 32'hA5);
        chk("uni_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("uni_busy_fall", busy, 0);
        tick();

        // multicast
        push(4'hF, 5'd1, 32'h11);
        @(negedge clk);
        chk("mc_valid", pe_valid, 6'b010010);
        tick(); tick();

        // backpressure on PE 4
        pe_ready = 6'b101111;
        push(4'hF, 5'd1, 32'h22);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", pe_valid, 0);
            tick();
        end
        pe_ready = '1;
        @(negedge clk);
        chk("bp_deliver", pe_valid, 6'b010010);
        tick();
        @(negedge clk);
        chk("bp_no_dup", pe_valid, 0);
        chk("bp_busy", busy, 0);
        tick();

        // full then drop
        pe_ready = '0;
        for (int i = 0; i < 4; i++) push(4'd0, 5'd0, 32'h40 + i);
        @(negedge clk);
        chk("full_ready", ready, 0);
        enable = 1; row_tag = 0; col_tag = 0; value = 32'h99; tick(); enable = 0;
        pe_ready = '1;
        repeat (5) tick();
        push(4'd3, 5'd7, 32'h77);
        @(negedge clk);
        chk("drop_valid", pe_valid, 0);
        chk("drop_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("drop_count", drop_count, 16'd1);
        chk("drop_busy_fall", busy, 0);
        tick();

        // rescan with two entries buffered
        pe_ready = '0;
        push(4'd0, 5'd0, 32'h100);
        push(4'd1, 5'd1, 32'h101);
        set_id = 1; pe_ready = '1;
        for (int i = 0; i < 6; i++) begin
            id_scan_in = ids_b[i];
            @(negedge clk);
            chk("scan_ready", ready, 0);
            chk("scan_valid", pe_valid, 0);
            tick();
        end
        set_id = 0;
        @(negedge clk);
        chk("scan_first", pe_valid, 6'b000100);
        chk("scan_first_val", pe_value, 32'h100);
        tick();
        @(negedge clk);
        chk("scan_second", pe_valid, 6'b010000);
        chk("scan_second_val", pe_value, 32'h101);
        tick(); tick();

        // asynchronous reset with three buffered entries
        pe_ready = '0;
        push(4'd0, 5'd0, 32'h1);
        push(4'd0, 5'd0, 32'h2);
        push(4'd0, 5'd0, 32'h3);
        pe_ready = '1;
        #1;
        chk("pre_reset_valid", pe_valid, 6'b000100);
        #1 rst = 0;
        #1;
        chk("async_ready", ready, 0);
        chk("async_busy", busy, 0);
        chk("async_valid", pe_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rel_ready", ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("rel_no_deliver", pe_valid, 0);
            chk("rel_busy", busy, 0);
        end
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
